// File: rtl/otter_fetch_stage.sv
// OTTER instruction-fetch stage: owns the PC, issues 1-cycle imem reads and queues {pc, ir} for decode.
// Optional misaligned-redirect fault enabled by defining OTTER_FETCH_MISALIGN_EN.
module otter_fetch_stage #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter int          DEPTH     = 2
) (
   input  logic        CLK,
   input  logic        RESET_N,
   output logic        imem_rd,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        de_valid,
   input  logic        de_ready,
   output logic [31:0] de_pc,
   output logic [31:0] de_ir,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fetch_misalign
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0] pc_q;
   logic [31:0] req_pc_q;
   logic        inflight_q;
   logic        drop_q;
   logic        halt_q;
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;

   logic [31:0] pc_mem [DEPTH];
   logic [31:0] ir_mem [DEPTH];

   logic          empty;
   logic          full;
   logic          pop;
   logic          push;
   logic          issue;
   logic [AW+1:0] occ;
   logic [AW+1:0] level;
   logic [31:0]   target_pc;
   logic          target_misalign;

`ifdef OTTER_FETCH_MISALIGN_EN
   assign target_pc       = redirect_pc;
   assign target_misalign = |redirect_pc[1:0];
`else
   assign target_pc       = redirect_pc & 32'hFFFF_FFFC;
   assign target_misalign = 1'b0;
`endif

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign occ   = {1'b0, wr_ptr_q - rd_ptr_q};

   assign pop   = de_valid & de_ready;
   assign push  = inflight_q & ~drop_q;

   // Slots already promised (queued + in flight), less the one leaving this cycle.
   assign level = occ + (AW+2)'(inflight_q) - (AW+2)'(pop);
   assign issue = RESET_N & ~redirect & ~halt_q & (level < (AW+2)'(DEPTH));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pc_q       <= RESET_VEC;
         req_pc_q   <= 32'h0;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
         halt_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else if (redirect) begin
         pc_q       <= target_pc;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         drop_q     <= inflight_q;
         inflight_q <= 1'b0;
         halt_q     <= target_misalign;
      end else begin
         drop_q <= 1'b0;
         if (issue) begin
            pc_q       <= pc_q + 32'd4;
            req_pc_q   <= pc_q;
            inflight_q <= 1'b1;
         end else begin
            inflight_q <= 1'b0;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge CLK) begin
      if (push && !redirect) begin
         pc_mem[wr_ptr_q[AW-1:0]] <= req_pc_q;
         ir_mem[wr_ptr_q[AW-1:0]] <= imem_rdata;
      end
   end

   assign imem_rd        = issue;
   assign imem_addr      = pc_q;
   assign de_valid       = ~empty;
   assign de_pc          = de_valid ? pc_mem[rd_ptr_q[AW-1:0]] : 32'h0;
   assign de_ir          = de_valid ? ir_mem[rd_ptr_q[AW-1:0]] : 32'h0;
   assign fetch_misalign = halt_q;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Directed bench for otter_fetch_stage; memory returns addr ^ 32'hA5A5_0000.
module tb_otter_fetch_stage;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        imem_rd;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        de_valid;
   logic        de_ready = 1'b0;
   logic [31:0] de_pc;
   logic [31:0] de_ir;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        fetch_misalign;

   int checks = 0;
   int errors = 0;

   otter_fetch_stage #(.RESET_VEC(32'h0000_0000), .DEPTH(2)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .de_valid(de_valid), .de_ready(de_ready), .de_pc(de_pc), .de_ir(de_ir),
      .redirect(redirect), .redirect_pc(redirect_pc), .fetch_misalign(fetch_misalign)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (imem_rd) imem_rdata <= imem_addr ^ KEY;
   end

   always @(posedge CLK) begin
      if (RESET_N && !redirect && dut.push && dut.full && !dut.pop) begin
         errors++;
         $display("FAIL fifo_overflow got push_when_full=1 want 0");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      repeat (3) @(negedge CLK);
      #1;
      checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", imem_rd); end
      checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", de_valid); end
      checks++; if (de_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", de_pc); end
      checks++; if (de_ir !== 32'h0) begin errors++; $display("FAIL reset_ir got %h want 0", de_ir); end
      checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", fetch_misalign); end
   endtask

   // Release reset and check the fill: address 4k in cycle k, head 4(k-2) from cycle 2.
   task automatic test_fill(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge CLK);
         RESET_N = 1'b1; de_ready = 1'b1;
         #1;
         checks++; if (imem_rd !== 1'b1 || imem_addr !== 32'(4*k)) begin
            errors++; $display("FAIL fill_addr k=%0d got rd=%b addr=%h want rd=1 addr=%h", k, imem_rd, imem_addr, 32'(4*k)); end
         if (k < 2) begin
            checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL fill_early_valid k=%0d got %b want 0", k, de_valid); end
         end else begin
            checks++; if (de_valid !== 1'b1 || de_pc !== 32'(4*(k-2)) || de_ir !== (32'(4*(k-2)) ^ KEY)) begin
               errors++; $display("FAIL fill_head k=%0d got v=%b pc=%h ir=%h want v=1 pc=%h", k, de_valid, de_pc, de_ir, 32'(4*(k-2))); end
         end
      end
   endtask

   // Entered in cycle 8 of steady stream: head 24, next fetch 32.
   task automatic test_stall();
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         de_ready = 1'b0;
         #1;
         checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL stall_rd i=%0d got %b want 0", i, imem_rd); end
         checks++; if (de_valid !== 1'b1 || de_pc !== 32'd24 || de_ir !== (32'd24 ^ KEY)) begin
            errors++; $display("FAIL stall_hold i=%0d got v=%b pc=%h ir=%h want v=1 pc=00000018", i, de_valid, de_pc, de_ir); end
      end
      for (int j = 0; j < 6; j++) begin
         @(negedge CLK);
         de_ready = 1'b1;
         #1;
         checks++; if (de_valid !== 1'b1 || de_pc !== 32'(24 + 4*j)) begin
            errors++; $display("FAIL resume_pc j=%0d got v=%b pc=%h want v=1 pc=%h", j, de_valid, de_pc, 32'(24 + 4*j)); end
         checks++; if (imem_rd !== 1'b1 || imem_addr !== 32'(32 + 4*j)) begin
            errors++; $display("FAIL resume_addr j=%0d got rd=%b addr=%h want rd=1 addr=%h", j, imem_rd, imem_addr, 32'(32 + 4*j)); end
      end
   endtask

   // After a redirect cycle: two empty cycles with fetch at tgt, tgt+4, then tgt, tgt+4, ... delivered.
   task automatic check_after_redirect(input string nm, input logic [31:0] tgt, input int n);
      @(negedge CLK);
      redirect = 1'b0;
      #1;
      checks++; if (de_valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== tgt) begin
         errors++; $display("FAIL %s_first got v=%b rd=%b addr=%h want v=0 rd=1 addr=%h", nm, de_valid, imem_rd, imem_addr, tgt); end
      @(negedge CLK);
      #1;
      checks++; if (de_valid !== 1'b0 || imem_addr !== tgt + 32'd4) begin
         errors++; $display("FAIL %s_second got v=%b addr=%h want v=0 addr=%h", nm, de_valid, imem_addr, tgt + 32'd4); end
      for (int j = 0; j < n; j++) begin
         @(negedge CLK);
         #1;
         checks++; if (de_valid !== 1'b1 || de_pc !== tgt + 32'(4*j) || de_ir !== ((tgt + 32'(4*j)) ^ KEY)) begin
            errors++; $display("FAIL %s_deliver j=%0d got v=%b pc=%h ir=%h want v=1 pc=%h", nm, j, de_valid, de_pc, de_ir, tgt + 32'(4*j)); end
      end
   endtask

   task automatic test_redirect_inflight();
      @(negedge CLK);
      redirect = 1'b1; redirect_pc = 32'h100;
      #1;
      checks++; if (imem_rd !== 1'b0 || dut.inflight_q !== 1'b1) begin
         errors++; $display("FAIL rdinf_cycle got rd=%b inflight=%b want rd=0 inflight=1", imem_rd, dut.inflight_q); end
      check_after_redirect("rdinf", 32'h100, 3);
   endtask

   task automatic fill_fifo(input string nm);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         de_ready = 1'b0;
      end
      #1;
      checks++; if (de_valid !== 1'b1 || imem_rd !== 1'b0) begin
         errors++; $display("FAIL %s_full got v=%b rd=%b want v=1 rd=0", nm, de_valid, imem_rd); end
   endtask

   task automatic test_redirect_full_pop();
      fill_fifo("rdpop");
      @(negedge CLK);
      de_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
      #1;
      checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL rdpop_cycle got rd=%b want 0", imem_rd); end
      check_after_redirect("rdpop", 32'h100, 3);
   endtask

   task automatic test_misalign();
      @(negedge CLK);
      redirect = 1'b1; redirect_pc = 32'h102;
      #1;
      checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL mis_cycle got rd=%b want 0", imem_rd); end
`ifdef OTTER_FETCH_MISALIGN_EN
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         redirect = 1'b0;
         #1;
         checks++; if (fetch_misalign !== 1'b1 || imem_rd !== 1'b0 || de_valid !== 1'b0) begin
            errors++; $display("FAIL mis_halt i=%0d got mis=%b rd=%b v=%b want mis=1 rd=0 v=0", i, fetch_misalign, imem_rd, de_valid); end
      end
      @(negedge CLK);
      redirect = 1'b1; redirect_pc = 32'h200;
      #1;
      checks++; if (fetch_misalign !== 1'b1 || imem_rd !== 1'b0) begin
         errors++; $display("FAIL mis_clear_cycle got mis=%b rd=%b want mis=1 rd=0", fetch_misalign, imem_rd); end
      check_after_redirect("mis_resume", 32'h200, 2);
      checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_cleared got %b want 0", fetch_misalign); end
`else
      check_after_redirect("mis_forced", 32'h100, 2);
      checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_tied got %b want 0", fetch_misalign); end
`endif
   endtask

   task automatic test_wrap();
      @(negedge CLK);
      de_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      check_after_redirect("wrap", 32'hFFFF_FFF8, 3);
      checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL wrap_fault got %b want 0", fetch_misalign); end
   endtask

   task automatic test_reset_midstream();
      fill_fifo("rstmid");
      @(negedge CLK);
      de_ready = 1'b1; RESET_N = 1'b0;
      #1;
      checks++; if (imem_rd !== 1'b0 || de_valid !== 1'b0 || de_pc !== 32'h0 || de_ir !== 32'h0 || fetch_misalign !== 1'b0) begin
         errors++; $display("FAIL rstmid_async got rd=%b v=%b pc=%h ir=%h mis=%b want all 0", imem_rd, de_valid, de_pc, de_ir, fetch_misalign); end
      repeat (2) @(negedge CLK);
      #1;
      checks++; if (imem_rd !== 1'b0 || de_valid !== 1'b0) begin
         errors++; $display("FAIL rstmid_hold got rd=%b v=%b want 0 0", imem_rd, de_valid); end
      test_fill(5);
   endtask

   initial begin
      test_reset();
      test_fill(8);
      test_stall();
      test_redirect_inflight();
      test_redirect_full_pop();
      test_misalign();
      test_wrap();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
